// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the RV32 pipeline and its stall/flush sequencer.
// master = pipeline side (drives hazard inputs); slave = sequencer (drives stall/flush).
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             i_busywait;
    logic             d_busywait;
    logic             branch_jump_signal;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             switch_cache_req;
    logic             cache_switch_ack;

    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_stall;
    logic             id_ex_flush;
    logic             ex_mem_stall;
    logic             mem_wb_stall;
    logic             cache_switch_start;
    logic             switch_err;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output i_busywait, d_busywait, branch_jump_signal, ex_mem_read, ex_rd,
               id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, switch_cache_req, cache_switch_ack,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_stall, cache_switch_start, switch_err, ctrl_state, stall_cycles
    );

    modport slave (
        input  i_busywait, d_busywait, branch_jump_signal, ex_mem_read, ex_rd,
               id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, switch_cache_req, cache_switch_ack,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_stall, cache_switch_start, switch_err, ctrl_state, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory busywait, load-use, branch flush, cache switch.
// Latency: stall/flush are same-cycle combinational; state and counters update on the next rising edge.
// Backpressure: any cache busywait holds every pipeline register and freezes the sequencer.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int ACK_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam int DW = $clog2(DRAIN_CYCLES) + 1;
    localparam int WW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_RESUME = 2'd3
    } state_e;

    state_e           state_q;
    logic [DW-1:0]    drain_cnt_q;
    logic [WW-1:0]    wait_cnt_q;
    logic             err_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic busy;
    logic branch_act;
    logic load_use;

    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_stall;
    logic switch_start;

    assign busy = hz.i_busywait | hz.d_busywait;

    // Once the switch has begun the pipeline behind ID is empty, so a branch cannot be in EX.
    assign branch_act = hz.branch_jump_signal & ~busy &
                        ((state_q == ST_RUN) | (state_q == ST_DRAIN));

    assign load_use = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                      ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                       (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        switch_start = 1'b0;
        if (reset) begin
            pc_stall = 1'b0;
        end else if (busy) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
        end else if (branch_act) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // Switch request and load-use both want the same hold-plus-bubble pattern.
                    if (hz.switch_cache_req || load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
                ST_SWITCH: begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_stall = 1'b1;
                    switch_start = (wait_cnt_q == '0);
                end
                default: begin
                    pc_stall = 1'b0;
                end
            endcase
        end
    end

    assign stall_cnt_d = (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) ? stall_cnt_q + 1'b1
                                                                      : stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            if (!busy) begin
                case (state_q)
                    ST_RUN: begin
                        if (!hz.branch_jump_signal && hz.switch_cache_req) begin
                            state_q     <= ST_DRAIN;
                            drain_cnt_q <= '0;
                        end
                    end
                    ST_DRAIN: begin
                        if (hz.branch_jump_signal) begin
                            state_q     <= ST_RUN;
                            drain_cnt_q <= '0;
                        end else if (drain_cnt_q == DRAIN_LAST) begin
                            state_q     <= ST_SWITCH;
                            drain_cnt_q <= '0;
                            wait_cnt_q  <= '0;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + 1'b1;
                        end
                    end
                    ST_SWITCH: begin
                        if (hz.cache_switch_ack) begin
                            state_q <= ST_RESUME;
                        end else if (wait_cnt_q == WAIT_LAST) begin
                            state_q <= ST_RESUME;
                            err_q   <= 1'b1;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= ST_RUN;
                        wait_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign hz.pc_stall           = pc_stall;
    assign hz.if_id_stall        = if_id_stall;
    assign hz.if_id_flush        = if_id_flush;
    assign hz.id_ex_stall        = id_ex_stall;
    assign hz.id_ex_flush        = id_ex_flush;
    assign hz.ex_mem_stall       = ex_mem_stall;
    assign hz.mem_wb_stall       = mem_wb_stall;
    assign hz.cache_switch_start = switch_start;
    assign hz.switch_err         = err_q;
    assign hz.ctrl_state         = state_q;
    assign hz.stall_cycles       = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed corner sequences, random vs model.
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN = 3;
    localparam int ACK   = 64;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    localparam logic [6:0] V_NONE   = 7'b0000000;
    localparam logic [6:0] V_ALL    = 7'b1101011;
    localparam logic [6:0] V_BUBBLE = 7'b1100100;
    localparam logic [6:0] V_FLUSH  = 7'b0010100;

    typedef struct packed {
        logic       ibw;
        logic       dbw;
        logic       br;
        logic       mr;
        logic [4:0] exrd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       req;
        logic       ack;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] exp;
    } vec_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    int   n_starts;

    // observed values of the most recent step
    logic [6:0] s_vec;
    int         s_state;
    int         s_err;
    int         s_cnt;

    // reference model: mode 0 run, 1 drain, 2 switch, 3 resume
    int m_mode;
    int m_drain_left;
    int m_elapsed;
    int m_err;
    int m_cnt;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES(DRAIN),
        .ACK_TIMEOUT (ACK),
        .CNT_W       (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        bus.i_busywait         = v.ibw;
        bus.d_busywait         = v.dbw;
        bus.branch_jump_signal = v.br;
        bus.ex_mem_read        = v.mr;
        bus.ex_rd              = v.exrd;
        bus.id_rs1             = v.rs1;
        bus.id_rs2             = v.rs2;
        bus.id_uses_rs1        = v.u1;
        bus.id_uses_rs2        = v.u2;
        bus.switch_cache_req   = v.req;
        bus.cache_switch_ack   = v.ack;
    endtask

    function automatic logic [6:0] dut_vec();
        return {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
                bus.id_ex_flush, bus.ex_mem_stall, bus.mem_wb_stall};
    endfunction

    function automatic bit is_load_use(input in_t v);
        if (!v.mr || v.exrd == 5'd0) return 1'b0;
        return (v.u1 && v.rs1 == v.exrd) || (v.u2 && v.rs2 == v.exrd);
    endfunction

    function automatic logic [6:0] model_vec(input in_t v);
        if (v.ibw || v.dbw) return V_ALL;
        if (v.br && (m_mode == 0 || m_mode == 1)) return V_FLUSH;
        case (m_mode)
            0: return (v.req || is_load_use(v)) ? V_BUBBLE : V_NONE;
            1: return V_BUBBLE;
            2: return V_ALL;
            default: return V_NONE;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_drain_left = 0; m_elapsed = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_advance(input in_t v);
        logic [6:0] e;
        e = model_vec(v);
        if (e[6]) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        if (v.ibw || v.dbw) return;
        case (m_mode)
            0: if (!v.br && v.req) begin m_mode = 1; m_drain_left = DRAIN; end
            1: begin
                if (v.br) m_mode = 0;
                else begin
                    m_drain_left--;
                    if (m_drain_left == 0) begin m_mode = 2; m_elapsed = 0; end
                end
            end
            2: begin
                m_elapsed++;
                if (v.ack) m_mode = 3;
                else if (m_elapsed == ACK) begin m_err = 1; m_mode = 3; end
            end
            default: m_mode = 0;
        endcase
    endtask

    // Apply one cycle of inputs, check against the model mid-cycle, then advance the model.
    task automatic step(input in_t v);
        int exp_start;
        @(negedge clk);
        drive(v);
        #1;
        exp_start = (m_mode == 2 && m_elapsed == 0 && !v.ibw && !v.dbw) ? 1 : 0;
        s_vec   = dut_vec();
        s_state = int'(bus.ctrl_state);
        s_err   = int'(bus.switch_err);
        s_cnt   = int'(bus.stall_cycles);
        if (bus.cache_switch_start) n_starts++;
        chk("stall_flush", int'(s_vec), int'(model_vec(v)));
        chk("start", int'(bus.cache_switch_start), exp_start);
        chk("state", s_state, m_mode);
        chk("switch_err", s_err, m_err);
        chk("stall_cycles", s_cnt, m_cnt);
        model_advance(v);
    endtask

    task automatic do_reset();
        in_t z;
        z = '0;
        @(negedge clk);
        drive(z);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_starts = 0;
    endtask

    function automatic in_t mk_lu(input logic mr, input int exrd, input int rs1, input int rs2,
                                  input logic u1, input logic u2);
        in_t v;
        v      = '0;
        v.mr   = mr;
        v.exrd = 5'(exrd);
        v.rs1  = 5'(rs1);
        v.rs2  = 5'(rs2);
        v.u1   = u1;
        v.u2   = u2;
        return v;
    endfunction

    initial begin
        vec_t tbl[8];
        int   exp_states[12];
        in_t  idle;
        in_t  v;

        n_chk = 0; n_err = 0; n_starts = 0;
        idle  = '0;
        reset = 1'b1;
        drive(idle);
        model_reset();

        tbl[0] = '{mk_lu(1, 5, 0, 5, 0, 1), V_BUBBLE};
        tbl[1] = '{mk_lu(1, 0, 0, 0, 1, 1), V_NONE};
        tbl[2] = '{mk_lu(1, 7, 7, 3, 1, 0), V_BUBBLE};
        tbl[3] = '{mk_lu(1, 7, 7, 7, 0, 0), V_NONE};
        tbl[4] = '{mk_lu(0, 9, 9, 9, 1, 1), V_NONE};
        tbl[5] = '{mk_lu(1, 9, 8, 10, 1, 1), V_NONE};
        tbl[6] = '{mk_lu(1, 31, 4, 31, 1, 1), V_BUBBLE};
        tbl[7] = '{mk_lu(1, 12, 12, 12, 1, 1), V_BUBBLE};

        // 1: reset then idle
        do_reset();
        for (int i = 0; i < 10; i++) step(idle);
        chk("idle_vec", int'(s_vec), 0);
        chk("idle_state", s_state, 0);
        chk("idle_cnt", s_cnt, 0);

        // 2: load-use table from RUN
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].in);
            chk($sformatf("lu_vec%0d", i), int'(s_vec), int'(tbl[i].exp));
        end

        // 3: data busywait during load-use
        do_reset();
        v = mk_lu(1, 5, 0, 5, 0, 1);
        v.dbw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(v);
            chk("busy_vec", int'(s_vec), int'(V_ALL));
        end
        v.dbw = 1'b0;
        step(v);
        chk("lu_after_busy", int'(s_vec), int'(V_BUBBLE));
        step(idle);
        chk("busy_cnt", s_cnt, 5);

        // 4: cache switch acked 5 cycles after start
        do_reset();
        exp_states = '{0, 1, 1, 1, 2, 2, 2, 2, 2, 2, 3, 0};
        for (int i = 0; i < 12; i++) begin
            v = idle;
            v.req = (i == 0);
            v.ack = (i == 9);
            step(v);
            chk($sformatf("sw_state%0d", i), s_state, exp_states[i]);
        end
        chk("sw_starts", n_starts, 1);
        chk("sw_resume_vec", int'(s_vec), 0);

        // 5: branch aborts drain
        do_reset();
        v = idle; v.req = 1'b1;
        step(v);
        step(idle);
        v = idle; v.br = 1'b1;
        step(v);
        chk("abort_vec", int'(s_vec), int'(V_FLUSH));
        chk("abort_state_in", s_state, 1);
        for (int i = 0; i < 6; i++) step(idle);
        chk("abort_state", s_state, 0);
        chk("abort_starts", n_starts, 0);

        // 6: ack timeout, counter saturation
        do_reset();
        for (int i = 0; i < 70; i++) begin
            v = idle;
            v.req = (i == 0);
            step(v);
            if (i == 67) begin
                chk("to_last_switch", s_state, 2);
                chk("to_err_early", s_err, 0);
            end
            if (i == 68) begin
                chk("to_resume", s_state, 3);
                chk("to_err", s_err, 1);
            end
        end
        chk("to_run", s_state, 0);
        chk("to_sat", s_cnt, CMAX);
        chk("to_starts", n_starts, 1);

        // async reset mid-switch
        do_reset();
        v = idle; v.req = 1'b1;
        step(v);
        for (int i = 0; i < 5; i++) step(idle);
        @(negedge clk);
        v = idle; v.dbw = 1'b1;
        drive(v);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_vec", int'(dut_vec()), 0);
        chk("arst_state", int'(bus.ctrl_state), 0);
        chk("arst_start", int'(bus.cache_switch_start), 0);
        @(negedge clk);
        drive(idle);
        reset = 1'b0;
        model_reset();

        // random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            v      = '0;
            v.ibw  = ($urandom_range(0, 19) == 0);
            v.dbw  = ($urandom_range(0, 14) == 0);
            v.br   = ($urandom_range(0, 9) == 0);
            v.mr   = $urandom_range(0, 1);
            v.exrd = 5'($urandom_range(0, 3));
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.u1   = $urandom_range(0, 1);
            v.u2   = $urandom_range(0, 1);
            v.req  = ($urandom_range(0, 15) == 0);
            v.ack  = ($urandom_range(0, 7) == 0);
            step(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
